// File: rtl/vc_input_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vc_input_buffer_pkg
// Shared NoC definitions used by the virtual-channel input buffer and its
// per-VC FIFO: number of virtual channels, flit label and flit layout, and
// the per-VC packet-tracking state encoding.
// ---------------------------------------------------------------------------
package vc_input_buffer_pkg;

    localparam int VC_NUM         = 2;
    localparam int VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int FLIT_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10
    } vc_state_t;

    // A flit carrying either label closes the packet it belongs to.
    function automatic logic isTailLabel(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo
// Circular flit FIFO holding the buffered flits of one virtual channel.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   i_data      flit to write
//   i_push      write strobe (caller decides acceptance; a full FIFO
//               without a same-cycle pop still refuses it)
//   i_pop       read strobe, ignored when the FIFO is empty
//   o_data      head flit (valid when o_isEmpty = 0)
//   o_isEmpty   FIFO holds no flits
//   o_count     number of stored flits, 0 .. BUFFER_SIZE
// ---------------------------------------------------------------------------
module vc_fifo
    import vc_input_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  flit_t                        i_data,
    input  logic                         i_push,
    input  logic                         i_pop,
    output flit_t                        o_data,
    output logic                         o_isEmpty,
    output logic [$clog2(BUFFER_SIZE):0] o_count
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    flit_t              r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]   r_readPtr;
    logic [PTR_W-1:0]   r_writePtr;
    logic [CNT_W-1:0]   r_count;

    logic               w_doPush;
    logic               w_doPop;
    logic               w_full;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_full   = (r_count == CNT_W'(BUFFER_SIZE));
    assign w_doPop  = i_pop && (r_count != '0);
    assign w_doPush = i_push && (!w_full || w_doPop);

    // Storage carries no reset: the empty flag guards stale contents.
    always_ff @(posedge clk) begin
        if (w_doPush && !rst) begin
            r_mem[r_writePtr] <= i_data;
        end
    end

    // Pointers wrap naturally because BUFFER_SIZE is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_readPtr  <= '0;
            r_writePtr <= '0;
            r_count    <= '0;
        end else begin
            if (w_doPush) begin
                r_writePtr <= r_writePtr + 1'b1;
            end
            if (w_doPop) begin
                r_readPtr <= r_readPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data    = r_mem[r_readPtr];
    assign o_isEmpty = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/vc_input_buffer.sv
// ---------------------------------------------------------------------------
// vc_input_buffer
// Router input port with one FIFO per virtual channel. Incoming flits are
// steered by vc_id, checked against buffer space and packet protocol, and
// either stored or dropped with an error pulse. Each VC tracks the packet
// it holds so it can report when it is free for a new packet.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   data_i             incoming flit
//   valid_flit_i       data_i valid this cycle
//   on_off_o           per-VC credit: 1 = upstream may keep sending
//   vc_allocatable_o   per-VC: 1 = VC free for a new packet
//   read_i             per-VC pop strobe from the consumer
//   data_o             head flit of every VC FIFO
//   is_empty_o         per-VC FIFO empty
//   error_o            one-cycle pulse, the cycle after a flit was dropped
// ---------------------------------------------------------------------------
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE   = 8,
    parameter int ON_OFF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  flit_t                data_i,
    input  logic                 valid_flit_i,
    output logic  [VC_NUM-1:0]   on_off_o,
    output logic  [VC_NUM-1:0]   vc_allocatable_o,
    input  logic  [VC_NUM-1:0]   read_i,
    output flit_t [VC_NUM-1:0]   data_o,
    output logic  [VC_NUM-1:0]   is_empty_o,
    output logic                 error_o
);

    localparam int CNT_W    = $clog2(BUFFER_SIZE) + 1;
    localparam int ON_LIMIT = BUFFER_SIZE - ON_OFF_MARGIN;

    vc_state_t          r_state [VC_NUM];
    logic [VC_NUM-1:0]  r_allocatable;
    logic               r_error;

    logic [CNT_W-1:0]   w_count [VC_NUM];
    flit_t              w_fifoData [VC_NUM];
    logic [VC_NUM-1:0]  w_empty;
    logic [VC_NUM-1:0]  w_push;
    logic [VC_NUM-1:0]  w_pop;
    logic               w_anyDrop;

    // Per-VC admission: the flit must fit (counting a same-cycle pop) and
    // must continue the packet the VC is tracking. Anything else, including
    // a vc_id that matches no VC, is dropped and reported.
    always_comb begin
        logic w_target;
        logic w_space;
        logic w_legal;
        logic w_hit;
        w_push    = '0;
        w_pop     = '0;
        w_anyDrop = 1'b0;
        w_hit     = 1'b0;
        w_target  = 1'b0;
        w_space   = 1'b0;
        w_legal   = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_pop[v] = read_i[v] && !w_empty[v];
            w_target = valid_flit_i && (int'(data_i.vc_id) == v);
            w_space  = (w_count[v] - CNT_W'(w_pop[v])) < CNT_W'(BUFFER_SIZE);
            case (r_state[v])
                IDLE:    w_legal = (data_i.flit_label == HEAD) ||
                                   (data_i.flit_label == HEADTAIL);
                BUSY:    w_legal = (data_i.flit_label == BODY) ||
                                   (data_i.flit_label == TAIL);
                default: w_legal = 1'b0;
            endcase
            w_push[v] = w_target && w_space && w_legal;
            if (w_target) begin
                w_hit = 1'b1;
                if (!(w_space && w_legal)) begin
                    w_anyDrop = 1'b1;
                end
            end
        end
        if (valid_flit_i && !w_hit) begin
            w_anyDrop = 1'b1;
        end
    end

    // One FIFO per virtual channel; all share the incoming flit bus.
    for (genvar g = 0; g < VC_NUM; g++) begin : gVcFifo
        vc_fifo #(
            .BUFFER_SIZE (BUFFER_SIZE)
        ) u_vcFifo (
            .clk       (clk),
            .rst       (rst),
            .i_data    (data_i),
            .i_push    (w_push[g]),
            .i_pop     (w_pop[g]),
            .o_data    (w_fifoData[g]),
            .o_isEmpty (w_empty[g]),
            .o_count   (w_count[g])
        );
        assign data_o[g] = w_fifoData[g];
    end

    // Packet tracker per VC. A VC stays unavailable from the accepted head
    // until its tail leaves the FIFO, so a new packet never mixes with the
    // remains of the previous one. Pushes are never accepted in DRAIN, so
    // the pop-driven exit from DRAIN cannot collide with a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_state[v] <= IDLE;
            end
            r_allocatable <= '1;
            r_error       <= 1'b0;
        end else begin
            r_error <= w_anyDrop;
            for (int v = 0; v < VC_NUM; v++) begin
                case (r_state[v])
                    IDLE: begin
                        if (w_push[v] && data_i.flit_label == HEAD) begin
                            r_state[v]       <= BUSY;
                            r_allocatable[v] <= 1'b0;
                        end else if (w_push[v] && data_i.flit_label == HEADTAIL) begin
                            r_state[v]       <= DRAIN;
                            r_allocatable[v] <= 1'b0;
                        end
                    end
                    BUSY: begin
                        if (w_push[v] && data_i.flit_label == TAIL) begin
                            r_state[v] <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (w_pop[v] && isTailLabel(w_fifoData[v].flit_label)) begin
                            r_state[v]       <= IDLE;
                            r_allocatable[v] <= 1'b1;
                        end
                    end
                    default: begin
                        r_state[v]       <= IDLE;
                        r_allocatable[v] <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Credit decode from the registered occupancy: free slots must stay
    // above the margin for upstream to keep sending.
    always_comb begin
        on_off_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            on_off_o[v] = int'(w_count[v]) < ON_LIMIT;
        end
    end

    assign vc_allocatable_o = r_allocatable;
    assign is_empty_o       = w_empty;
    assign error_o          = r_error;

endmodule
